// File: rtl/custom_instruction_initiator.sv
// Issue-side master of the custom-instruction bus: one request in flight, start pulse,
// wait for a responder's done or a timeout, then hand back result/error.
module custom_instruction_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [7:0]  reqIseId,
   input  logic [31:0] reqValueA,
   input  logic [31:0] reqValueB,
   output logic        rspValid,
   input  logic        rspReady,
   output logic [31:0] rspResult,
   output logic        rspError,
   output logic        ciStart,
   output logic [7:0]  ciIseId,
   output logic [31:0] ciValueA,
   output logic [31:0] ciValueB,
   input  logic        ciDone,
   input  logic [31:0] ciResult
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [7:0]  id_q;
   logic [31:0] a_q, b_q, res_q;
   logic        err_q;
   logic [7:0]  cnt_q;
   logic        ld_req, ld_res, ld_to, clr_cnt, inc_cnt;
   logic        busy, out_en;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt_q <= 8'd0;
         id_q  <= 8'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         res_q <= 32'd0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ld_req) begin
            id_q <= reqIseId;
            a_q  <= reqValueA;
            b_q  <= reqValueB;
         end
         if (ld_res) begin
            res_q <= ciResult;
            err_q <= 1'b0;
         end else if (ld_to) begin
            res_q <= 32'd0;
            err_q <= 1'b1;
         end
         if (clr_cnt)      cnt_q <= 8'd0;
         else if (inc_cnt) cnt_q <= cnt_q + 8'd1;
      end
   end

   // A done in the last WAIT cycle is checked before the timeout, so it wins.
   always_comb begin
      state_nxt = state;
      ld_req    = 1'b0;
      ld_res    = 1'b0;
      ld_to     = 1'b0;
      clr_cnt   = 1'b0;
      inc_cnt   = 1'b0;
      case (state)
         IDLE: if (reqValid) begin
            ld_req    = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: if (ciDone) begin
            ld_res    = 1'b1;
            state_nxt = RESP;
         end else begin
            clr_cnt   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (ciDone) begin
            ld_res    = 1'b1;
            state_nxt = RESP;
         end else if (cnt_q == TO_LAST) begin
            ld_to     = 1'b1;
            state_nxt = RESP;
         end else begin
            inc_cnt   = 1'b1;
         end
         RESP: if (rspReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are forced low while reset is high, independent of the stored state.
   assign out_en    = !reset;
   assign busy      = out_en && (state == ISSUE || state == WAIT);
   assign reqReady  = out_en && (state == IDLE);
   assign rspValid  = out_en && (state == RESP);
   assign rspResult = rspValid ? res_q : 32'd0;
   assign rspError  = rspValid && err_q;
   assign ciStart   = out_en && (state == ISSUE);
   assign ciIseId   = busy ? id_q : 8'd0;
   assign ciValueA  = busy ? a_q  : 32'd0;
   assign ciValueB  = busy ? b_q  : 32'd0;

endmodule

// File: tb/tb_custom_instruction_initiator.sv
// Bench for custom_instruction_initiator: two instances (timeout 16 and 4), a configurable
// responder model and a cycle-phase reference model of the expected bus/response outputs.
module tb_custom_instruction_initiator;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reqValid = 1'b0, rspReady = 1'b0, sel = 1'b0;
   logic [7:0]  reqIseId = 8'd0;
   logic [31:0] reqValueA = 32'd0, reqValueB = 32'd0;

   logic [1:0]  rv_x, rr_x, reqReady_x, rspValid_x, rspError_x, ciStart_x;
   logic [31:0] rspResult_x [2];
   logic [7:0]  ciIseId_x [2];
   logic [31:0] ciValueA_x [2], ciValueB_x [2];

   // responder model
   logic        resp_en = 1'b0, resp_fn = 1'b0, force_done = 1'b0;
   int          resp_lat = 0, resp_cnt = 1000;
   logic [31:0] resp_val = 32'd0;
   logic        cur_start, model_done, ci_done;
   logic [31:0] ci_result;

   int checks = 0, errors = 0;

   always #5 clock = ~clock;

   function automatic logic [31:0] gray(input logic [31:0] p);
      int r, g, b;
      r = int'(p[15:11]) * 8;
      g = int'(p[10:5]) * 4;
      b = int'(p[4:0]) * 8;
      return 32'((r * 77 + g * 150 + b * 29) / 256);
   endfunction

   assign rv_x       = {reqValid & sel, reqValid & ~sel};
   assign rr_x       = {rspReady & sel, rspReady & ~sel};
   assign cur_start  = ciStart_x[sel];
   assign model_done = resp_en && ((cur_start && resp_lat == 0) ||
                                   (!cur_start && resp_lat > 0 && resp_cnt == resp_lat));
   assign ci_done    = model_done | force_done;
   assign ci_result  = force_done ? 32'hDEAD_BEEF :
                       model_done ? (resp_fn ? gray(ciValueA_x[sel]) : resp_val) : 32'd0;

   // cycles elapsed since the selected instance's start pulse
   always @(posedge clock) begin
      if (cur_start)            resp_cnt <= 1;
      else if (resp_cnt < 1000) resp_cnt <= resp_cnt + 1;
   end

   custom_instruction_initiator #(.TIMEOUT_CYCLES(16)) dut16 (
      .clock(clock), .reset(reset),
      .reqValid(rv_x[0]), .reqReady(reqReady_x[0]),
      .reqIseId(reqIseId), .reqValueA(reqValueA), .reqValueB(reqValueB),
      .rspValid(rspValid_x[0]), .rspReady(rr_x[0]),
      .rspResult(rspResult_x[0]), .rspError(rspError_x[0]),
      .ciStart(ciStart_x[0]), .ciIseId(ciIseId_x[0]),
      .ciValueA(ciValueA_x[0]), .ciValueB(ciValueB_x[0]),
      .ciDone(ci_done), .ciResult(ci_result));

   custom_instruction_initiator #(.TIMEOUT_CYCLES(4)) dut4 (
      .clock(clock), .reset(reset),
      .reqValid(rv_x[1]), .reqReady(reqReady_x[1]),
      .reqIseId(reqIseId), .reqValueA(reqValueA), .reqValueB(reqValueB),
      .rspValid(rspValid_x[1]), .rspReady(rr_x[1]),
      .rspResult(rspResult_x[1]), .rspError(rspError_x[1]),
      .ciStart(ciStart_x[1]), .ciIseId(ciIseId_x[1]),
      .ciValueA(ciValueA_x[1]), .ciValueB(ciValueB_x[1]),
      .ciDone(ci_done), .ciResult(ci_result));

   // observed output bundle of the selected instance
   logic [107:0] obs;
   assign obs = {reqReady_x[sel], rspValid_x[sel], rspError_x[sel], rspResult_x[sel],
                 ciStart_x[sel], ciIseId_x[sel], ciValueA_x[sel], ciValueB_x[sel]};

   localparam logic [107:0] IDLE_EXP = {1'b1, 107'd0};

   // One full transaction; lat<0 means no responder claims the id.
   task automatic run_txn(input string name, input logic s, input logic [7:0] id,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] val, input logic fn, input int bp);
      int to, e, guard;
      logic ok_lat, ee;
      logic [31:0] er;
      logic [107:0] exp;
      to = s ? 4 : 16;
      sel = s; resp_en = (lat >= 0); resp_lat = lat; resp_val = val; resp_fn = fn;
      rspReady = 1'b0;
      guard = 0;
      while (!reqReady_x[s] && guard < 40) begin @(negedge clock); guard++; end
      checks++;
      if (!reqReady_x[s]) begin
         errors++;
         $display("FAIL %s ready_wait reqReady=0 required 1 within 40 cycles", name);
         return;
      end
      reqValid = 1'b1; reqIseId = id; reqValueA = a; reqValueB = b;
      ok_lat = (lat >= 0) && (lat <= to);
      e  = ok_lat ? 2 + lat : 2 + to;
      er = ok_lat ? (fn ? gray(a) : val) : 32'd0;
      ee = !ok_lat;
      for (int n = 1; n <= e + bp + 1; n++) begin
         @(negedge clock);
         if (n == 1) reqValid = 1'b0;
         if (n == 1)          exp = {3'b000, 32'd0, 1'b1, id, a, b};
         else if (n < e)      exp = {3'b000, 32'd0, 1'b0, id, a, b};
         else if (n <= e + bp) exp = {1'b0, 1'b1, ee, er, 1'b0, 8'd0, 64'd0};
         else                 exp = IDLE_EXP;
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle T+%0d got=%h required=%h", name, n, obs, exp);
         end
         if (n == e + bp) rspReady = 1'b1;
         if (n == e + bp + 1) rspReady = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if (obs !== 108'd0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got=%h required=0", s, obs);
         end
      end
      sel = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (obs !== IDLE_EXP) begin
         errors++;
         $display("FAIL reset_release got=%h required=%h", obs, IDLE_EXP);
      end
   endtask

   task automatic test_comb_responder();
      run_txn("comb_id13", 1'b0, 8'd13, 32'd0, 32'd0, 0, 32'd0, 1'b1, 0);
      run_txn("comb_gray", 1'b0, 8'd13, 32'h0000_F81F, 32'd7, 0, 32'd0, 1'b1, 1);
   endtask

   task automatic test_timeout();
      run_txn("timeout_id47", 1'b0, 8'd47, 32'hA5A5_0001, 32'h5A5A_0002, -1, 32'd0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_txn("multicycle_bp", 1'b0, 8'd9, 32'h1111_2222, 32'h3333_4444, 5,
              32'h1234_ABCD, 1'b0, 3);
   endtask

   task automatic test_timeout_boundary();
      run_txn("edge_done_last", 1'b1, 8'd3, 32'hCAFE_0001, 32'h0BAD_0002, 4,
              32'h7777_8888, 1'b0, 0);
      run_txn("edge_done_late", 1'b1, 8'd3, 32'hCAFE_0003, 32'h0BAD_0004, 5,
              32'h9999_AAAA, 1'b0, 2);
      run_txn("edge_done_first", 1'b1, 8'd4, 32'h0000_0005, 32'h0000_0006, 1,
              32'h0101_0202, 1'b0, 0);
   endtask

   task automatic test_reset_mid_wait();
      sel = 1'b0; resp_en = 1'b0; rspReady = 1'b0;
      reqValid = 1'b1; reqIseId = 8'd21; reqValueA = 32'h1357_9BDF; reqValueB = 32'h2468_ACE0;
      @(negedge clock);                 // ISSUE
      reqValid = 1'b0;
      repeat (2) @(negedge clock);      // second WAIT cycle
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 108'd0) begin
         errors++;
         $display("FAIL rst_mid_wait_async_view got=%h required=0", obs);
      end
      @(negedge clock);
      checks++;
      if (obs !== 108'd0) begin
         errors++;
         $display("FAIL rst_mid_wait_held got=%h required=0", obs);
      end
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      force_done = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         checks++;
         if (obs !== IDLE_EXP) begin
            errors++;
            $display("FAIL rst_stray_done cycle=%0d got=%h required=%h", n, obs, IDLE_EXP);
         end
         @(negedge clock);
         force_done = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expq[$];
      int starts[$];
      int k, nresp;
      logic [31:0] a;
      sel = 1'b0; resp_en = 1'b1; resp_lat = 0; resp_fn = 1'b1; rspReady = 1'b1;
      k = 0; nresp = 0;
      for (int c = 0; c < 16; c++) begin
         if (ciStart_x[0]) starts.push_back(c);
         if (rspValid_x[0]) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_rsp got=%h required=none", rspResult_x[0]);
            end else begin
               a = expq.pop_front();
               if (rspResult_x[0] !== a || rspError_x[0] !== 1'b0) begin
                  errors++;
                  $display("FAIL b2b_result idx=%0d got=%h/%b required=%h/0",
                           nresp, rspResult_x[0], rspError_x[0], a);
               end
            end
            nresp++;
         end
         if (reqReady_x[0]) begin
            if (k < 3) begin
               a = $urandom;
               reqValid = 1'b1; reqIseId = 8'(13 + k); reqValueA = a; reqValueB = $urandom;
               expq.push_back(gray(a));
               k++;
            end else begin
               reqValid = 1'b0;
            end
         end
         @(negedge clock);
      end
      reqValid = 1'b0; rspReady = 1'b0;
      checks++;
      if (starts.size() != 3 || nresp != 3) begin
         errors++;
         $display("FAIL b2b_count starts=%0d rsps=%0d required 3/3", starts.size(), nresp);
      end
      for (int i = 1; i < starts.size(); i++) begin
         checks++;
         if (starts[i] - starts[i-1] != 3) begin
            errors++;
            $display("FAIL b2b_spacing gap=%0d required=3", starts[i] - starts[i-1]);
         end
      end
   endtask

   task automatic test_random();
      logic s, fn;
      int to, lat, bp;
      for (int i = 0; i < 14; i++) begin
         s   = 1'($urandom_range(0, 1));
         to  = s ? 4 : 16;
         lat = int'($urandom_range(0, to + 3)) - 1;
         bp  = int'($urandom_range(0, 3));
         fn  = 1'($urandom_range(0, 1));
         run_txn("random", s, 8'($urandom), $urandom, $urandom, lat, $urandom, fn, bp);
      end
   endtask

   initial begin
      test_reset();
      test_comb_responder();
      test_timeout();
      test_backpressure();
      test_timeout_boundary();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
